// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, frame defaults and parity modes.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line plus falling-edge detector.
// All flops reset to 1 so a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clock,
    input  logic reset,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rx_s = s2;
    assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with
// mid-bit sampling, delivering the byte and error flags on rx_valid.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_ODD = PAR_EVEN
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    uart_state_t state;
    uart_state_t state_d;

    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_q;
    logic                 rx_s;
    logic                 fall;
    logic                 tick_mid;
    logic                 tick_end;

    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .rx_in (rx_in),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    assign tick_mid = rx_tick && (tcnt == MID);
    assign tick_end = rx_tick && (tcnt == LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (fall) state_d = START;
            START:   if (tick_mid) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tick_end && (bcnt == BLAST)) state_d = PARITY;
            PARITY:  if (tick_end) state_d = STOP;
            STOP:    if (tick_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tcnt restarts on every state entry and at each bit boundary,
    // so OVERSAMPLE need not be a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if ((state_d != state) || tick_end) begin
            tcnt <= '0;
        end else if (rx_tick && (state != IDLE)) begin
            tcnt <= tcnt + TW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bcnt       <= '0;
            shreg      <= '0;
            par_q      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                START: bcnt <= '0;
                DATA: begin
                    if (tick_end) begin
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        bcnt  <= (bcnt == BLAST) ? '0 : bcnt + BW'(1);
                    end
                end
                PARITY: begin
                    if (tick_end) par_q <= (^shreg) ^ rx_s ^ ODD;
                end
                STOP: begin
                    if (tick_end) begin
                        rx_data    <= shreg;
                        parity_err <= par_q;
                        frame_err  <= ~rx_s;
                        rx_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
